// File: rtl/phase_iq_accum_if.sv
// phase_iq_accum_if: bus between the phase sequencer, the I/Q accumulator and
// the atan/direction stage. It carries the start/enable strobes, the sample,
// both reference values and the registered window result.
// The master is the sequencer/consumer side and the slave is the accumulator.
interface phase_iq_accum_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20,
   parameter int CNT_W  = 8
);
   // Sequencer side
   logic                     start;
   logic                     enable;
   logic signed [DATA_W-1:0] sample;
   logic signed [DATA_W-1:0] ref_i;
   logic signed [DATA_W-1:0] ref_q;

   // Result side
   logic signed [ACC_W-1:0]  i_sum;
   logic signed [ACC_W-1:0]  q_sum;
   logic [CNT_W-1:0]         n_samples;
   logic                     valid;
   logic                     busy;
   logic                     sat;

   modport master (
      output start, enable, sample, ref_i, ref_q,
      input  i_sum, q_sum, n_samples, valid, busy, sat
   );

   modport slave (
      input  start, enable, sample, ref_i, ref_q,
      output i_sum, q_sum, n_samples, valid, busy, sat
   );
endinterface

// File: rtl/phase_iq_accum.sv
// phase_iq_accum: multiplies each signed sample by the in-phase and quadrature
// references and sums both products over the window framed by start/enable.
// When enable drops, the sums and sample count are latched and announced with
// a one-cycle valid pulse.
// Optional build macro PHASE_IQ_ACCUM_SAT_EN: the accumulators clip to the
// signed ACC_W range and report clipping on sat. Without it they wrap modulo
// 2^ACC_W and sat is tied low.
// ACC_W must be >= 2*DATA_W so that a single product always fits.
module phase_iq_accum #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20,
   parameter int CNT_W  = 8
) (
   input logic             clock,
   input logic             reset,
   phase_iq_accum_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACC  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // Per-cycle control decoded by the FSM.
   logic w_load;    // open a new window with the current products
   logic w_accum;   // add the current products to the running window
   logic w_latch;   // close the window and publish the result

   // Running window.
   logic signed [ACC_W-1:0] r_acc_i;
   logic signed [ACC_W-1:0] r_acc_q;
   logic [CNT_W-1:0]        r_cnt;

   // Published result.
   logic signed [ACC_W-1:0] r_i_sum;
   logic signed [ACC_W-1:0] r_q_sum;
   logic [CNT_W-1:0]        r_n_samples;
   logic                    r_valid;
   logic                    r_busy;

   // Full-precision products, and the values the accumulators take next.
   logic signed [2*DATA_W-1:0] w_prod_i;
   logic signed [2*DATA_W-1:0] w_prod_q;
   logic signed [ACC_W-1:0]    w_base_i;
   logic signed [ACC_W-1:0]    w_base_q;
   logic signed [ACC_W-1:0]    w_next_i;
   logic signed [ACC_W-1:0]    w_next_q;
   logic [CNT_W-1:0]           w_cnt_next;

   // Window sequencing: decide the next state and which datapath action applies.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
      w_state_next = r_state;
      w_load       = 1'b0;
      w_accum      = 1'b0;
      w_latch      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start && bus.enable) begin
               w_load       = 1'b1;
               w_state_next = ST_ACC;
            end
         end
         ST_ACC: begin
            if (!bus.enable) begin
               w_latch      = 1'b1;
               w_state_next = ST_DONE;
            end else if (bus.start) begin
               // Restart: discard the partial window and load fresh.
               w_load       = 1'b1;
            end else begin
               w_accum      = 1'b1;
            end
         end
         ST_DONE: begin
            // A new window may open in the same cycle the result is announced.
            if (bus.start && bus.enable) begin
               w_load       = 1'b1;
               w_state_next = ST_ACC;
            end else begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      // NOTE: reset is sampled on the rising edge, so it is tested inside the clocked block and is absent from the sensitivity list.
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         // NOTE: sequential state uses <= so every register sees pre-edge values regardless of statement order.
         r_state <= w_state_next;
      end
   end

   // Operands are widened before multiplying so the product keeps full precision.
   assign w_prod_i = (2*DATA_W)'(bus.sample) * (2*DATA_W)'(bus.ref_i);
   assign w_prod_q = (2*DATA_W)'(bus.sample) * (2*DATA_W)'(bus.ref_q);

   // A load starts from zero, so load and accumulate share one adder.
   assign w_base_i = w_load ? '0 : r_acc_i;
   assign w_base_q = w_load ? '0 : r_acc_q;

`ifdef PHASE_IQ_ACCUM_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic signed [ACC_W:0] w_wide_i;
   logic signed [ACC_W:0] w_wide_q;
   logic                  w_clip_i;
   logic                  w_clip_q;
   logic                  r_sat_int;
   logic                  r_sat;

   // Add with one guard bit. Disagreeing top bits mean overflow, so clip to the rail.
   always_comb begin
      w_wide_i = (ACC_W+1)'(w_base_i) + (ACC_W+1)'(w_prod_i);
      w_wide_q = (ACC_W+1)'(w_base_q) + (ACC_W+1)'(w_prod_q);
      w_clip_i = w_wide_i[ACC_W] != w_wide_i[ACC_W-1];
      w_clip_q = w_wide_q[ACC_W] != w_wide_q[ACC_W-1];
      w_next_i = w_wide_i[ACC_W-1:0];
      w_next_q = w_wide_q[ACC_W-1:0];
      if (w_clip_i) begin
         w_next_i = w_wide_i[ACC_W] ? ACC_MIN : ACC_MAX;
      end
      if (w_clip_q) begin
         w_next_q = w_wide_q[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end

   // Sticky clip flag for the running window. A load starts it afresh.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sat_int <= 1'b0;
      end else if (w_load) begin
         r_sat_int <= w_clip_i | w_clip_q;
      end else if (w_accum) begin
         r_sat_int <= r_sat_int | w_clip_i | w_clip_q;
      end
   end

   // Publish the window's clip flag alongside the sums.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sat <= 1'b0;
      end else if (w_latch) begin
         r_sat <= r_sat_int;
      end
   end

   assign bus.sat = r_sat;
`else
   // Plain two's-complement adders; overflow wraps modulo 2^ACC_W.
   assign w_next_i = w_base_i + ACC_W'(w_prod_i);
   assign w_next_q = w_base_q + ACC_W'(w_prod_q);

   assign bus.sat  = 1'b0;
`endif

   // Sample count: a load restarts it at 1, and it holds at its maximum.
   always_comb begin
      w_cnt_next = r_cnt;
      if (w_load) begin
         w_cnt_next = CNT_W'(1);
      end else if (r_cnt != {CNT_W{1'b1}}) begin
         w_cnt_next = r_cnt + CNT_W'(1);
      end
   end

   // Running accumulators and count, advanced on every load or accumulate cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_acc_i <= '0;
         r_acc_q <= '0;
         r_cnt   <= '0;
      end else if (w_load || w_accum) begin
         r_acc_i <= w_next_i;
         r_acc_q <= w_next_q;
         r_cnt   <= w_cnt_next;
      end
   end

   // Result registers: hold the last window until the next one closes.
   // valid pulses for one cycle, and busy follows the ACC state.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_i_sum     <= '0;
         r_q_sum     <= '0;
         r_n_samples <= '0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_valid <= w_latch;
         r_busy  <= (w_state_next == ST_ACC);
         if (w_latch) begin
            r_i_sum     <= r_acc_i;
            r_q_sum     <= r_acc_q;
            r_n_samples <= r_cnt;
         end
      end
   end

   assign bus.i_sum     = r_i_sum;
   assign bus.q_sum     = r_q_sum;
   assign bus.n_samples = r_n_samples;
   assign bus.valid     = r_valid;
   assign bus.busy      = r_busy;

endmodule

// File: tb/tb_phase_iq_accum.sv
// tb_phase_iq_accum: directed and randomized windows driven into
// phase_iq_accum. Expected sums come from a plain-arithmetic model over the
// list of samples in each window. A second instance with ACC_W=16 exercises
// the overflow corner. The bench honours PHASE_IQ_ACCUM_SAT_EN the same way
// the design does.
module tb_phase_iq_accum;
   localparam int DATA_W  = 8;
   localparam int ACC_W   = 20;
   localparam int CNT_W   = 8;
   localparam int ACC_W16 = 16;
   localparam int CNT_MAX = (1 << CNT_W) - 1;
`ifdef PHASE_IQ_ACCUM_SAT_EN
   localparam bit SAT_EN = 1'b1;
`else
   localparam bit SAT_EN = 1'b0;
`endif

   logic clock;
   logic reset;

   int vectors          = 0;
   int miscompares      = 0;
   int cycle            = 0;
   int last_valid_cycle = 0;

   // Last published result, used to check that the outputs hold between windows.
   longint g_i   = 0;
   longint g_q   = 0;
   int     g_n   = 0;
   bit     g_sat = 1'b0;

   phase_iq_accum_if #(.DATA_W(DATA_W), .ACC_W(ACC_W),   .CNT_W(CNT_W)) bus ();
   phase_iq_accum_if #(.DATA_W(DATA_W), .ACC_W(ACC_W16), .CNT_W(CNT_W)) b16 ();

   phase_iq_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   phase_iq_accum #(.DATA_W(DATA_W), .ACC_W(ACC_W16), .CNT_W(CNT_W)) dut16 (
      .clock (clock),
      .reset (reset),
      .bus   (b16)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
      cycle++;
   endtask

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Sum of sample*ref over a window, with wrap or clip at acc_w bits.
   function automatic void model(input int smp[$], input int rf[$], input int acc_w,
                                 output longint sum, output bit sat);
      longint hi, lo, span;
      span = longint'(1) << acc_w;
      hi   = (span >> 1) - 1;
      lo   = -(span >> 1);
      sum  = 0;
      sat  = 1'b0;
      foreach (smp[k]) begin
         sum += longint'(smp[k]) * longint'(rf[k]);
         if (SAT_EN) begin
            if (sum > hi) begin
               sum = hi;
               sat = 1'b1;
            end else if (sum < lo) begin
               sum = lo;
               sat = 1'b1;
            end
         end else begin
            if (sum > hi) sum -= span;
            else if (sum < lo) sum += span;
         end
      end
   endfunction

   task automatic rand_sample(output int s);
      s = int'($urandom_range(255)) - 128;
   endtask

   // Drives one window of n enable cycles. When restart_at >= 0, start is
   // asserted again at that cycle, which discards the earlier samples.
   // The task then drops enable and checks the published result.
   task automatic run_window(input int n, input int restart_at, input bit rnd,
                             input bit chained, input int s_fix, input int ri_fix,
                             input int rq_fix);
      int     sq[$];
      int     iq[$];
      int     qq[$];
      int     s, ri, rq, n_exp;
      longint e_i, e_q;
      bit     sat_i, sat_q;
      for (int k = 0; k < n; k++) begin
         if (k == restart_at) begin
            sq.delete();
            iq.delete();
            qq.delete();
         end
         if (rnd) begin
            rand_sample(s);
            rand_sample(ri);
            rand_sample(rq);
         end else begin
            s  = s_fix;
            ri = ri_fix;
            rq = rq_fix;
         end
         bus.start  = (k == 0) || (k == restart_at);
         bus.enable = 1'b1;
         bus.sample = DATA_W'(s);
         bus.ref_i  = DATA_W'(ri);
         bus.ref_q  = DATA_W'(rq);
         sq.push_back(s);
         iq.push_back(ri);
         qq.push_back(rq);
         tick();
         check("busy_in_window", bus.busy, 1);
         check("valid_in_window", bus.valid, 0);
      end
      bus.enable = 1'b0;
      bus.start  = 1'($urandom_range(1));
      tick();
      n_exp = (sq.size() > CNT_MAX) ? CNT_MAX : sq.size();
      model(sq, iq, ACC_W, e_i, sat_i);
      model(sq, qq, ACC_W, e_q, sat_q);
      check("valid_pulse", bus.valid, 1);
      check("i_sum", bus.i_sum, 32'(e_i));
      check("q_sum", bus.q_sum, 32'(e_q));
      check("n_samples", bus.n_samples, n_exp);
      check("sat", bus.sat, 32'(sat_i | sat_q));
      check("busy_after_window", bus.busy, 0);
      if (chained) check("valid_spacing", cycle - last_valid_cycle, n + 1);
      last_valid_cycle = cycle;
      g_i   = e_i;
      g_q   = e_q;
      g_n   = n_exp;
      g_sat = sat_i | sat_q;
   endtask

   // Idle cycles: no valid, not busy, and the last result is held.
   task automatic idle_check(input int m);
      for (int k = 0; k < m; k++) begin
         bus.start  = 1'b0;
         bus.enable = 1'b0;
         tick();
         check("idle_valid", bus.valid, 0);
         check("idle_busy", bus.busy, 0);
         check("hold_i_sum", bus.i_sum, 32'(g_i));
         check("hold_q_sum", bus.q_sum, 32'(g_q));
         check("hold_n_samples", bus.n_samples, g_n);
         check("hold_sat", bus.sat, 32'(g_sat));
      end
   endtask

   initial begin
      int s;
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.enable = 1'b0;
      bus.sample = '0;
      bus.ref_i  = '0;
      bus.ref_q  = '0;
      b16.start  = 1'b0;
      b16.enable = 1'b0;
      b16.sample = '0;
      b16.ref_i  = '0;
      b16.ref_q  = '0;
      tick();
      tick();

      // Reset state.
      check("reset_i_sum", bus.i_sum, 0);
      check("reset_q_sum", bus.q_sum, 0);
      check("reset_n_samples", bus.n_samples, 0);
      check("reset_valid", bus.valid, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_sat", bus.sat, 0);
      check("reset16_i_sum", b16.i_sum, 0);
      reset = 1'b0;
      tick();

      // enable without start is ignored while idle.
      for (int k = 0; k < 5; k++) begin
         rand_sample(s);
         bus.start  = 1'b0;
         bus.enable = 1'b1;
         bus.sample = DATA_W'(s);
         bus.ref_i  = 8'sd5;
         bus.ref_q  = 8'sd7;
         tick();
         check("en_only_valid", bus.valid, 0);
         check("en_only_busy", bus.busy, 0);
         check("en_only_i_sum", bus.i_sum, 0);
         check("en_only_n_samples", bus.n_samples, 0);
      end
      // start without enable is ignored as well.
      bus.start  = 1'b1;
      bus.enable = 1'b0;
      tick();
      check("start_only_busy", bus.busy, 0);
      idle_check(1);

      // Sequencer pattern: 9 samples of 10 against refs 3 and -2.
      run_window(9, -1, 1'b0, 1'b0, 10, 3, -2);
      check("tp_i_sum_270", bus.i_sum, 270);
      check("tp_q_sum_m180", bus.q_sum, -180);
      check("tp_n_samples_9", bus.n_samples, 9);
      check("tp_sat_0", bus.sat, 0);
      idle_check(2);

      // Single-sample window and randomized windows.
      run_window(1, -1, 1'b1, 1'b0, 0, 0, 0);
      idle_check(1);
      for (int r = 0; r < 6; r++) begin
         run_window(1 + int'($urandom_range(11)), -1, 1'b1, 1'b0, 0, 0, 0);
         idle_check(1 + int'($urandom_range(2)));
      end

      // A restart mid-window reports only the samples after the restart.
      run_window(4, -1, 1'b1, 1'b0, 0, 0, 0);
      check("restart_first_n", bus.n_samples, 4);
      idle_check(1);
      run_window(7, 3, 1'b1, 1'b0, 0, 0, 0);
      check("restart_second_n", bus.n_samples, 4);
      idle_check(1);

      // Reset in the 5th cycle of a window aborts it.
      for (int k = 0; k < 4; k++) begin
         rand_sample(s);
         bus.start  = (k == 0);
         bus.enable = 1'b1;
         bus.sample = DATA_W'(s);
         tick();
      end
      reset      = 1'b1;
      bus.start  = 1'b0;
      bus.enable = 1'b1;
      tick();
      check("midreset_i_sum", bus.i_sum, 0);
      check("midreset_q_sum", bus.q_sum, 0);
      check("midreset_n_samples", bus.n_samples, 0);
      check("midreset_valid", bus.valid, 0);
      check("midreset_busy", bus.busy, 0);
      check("midreset_sat", bus.sat, 0);
      reset = 1'b0;
      g_i   = 0;
      g_q   = 0;
      g_n   = 0;
      g_sat = 1'b0;
      idle_check(3);
      run_window(9, -1, 1'b1, 1'b0, 0, 0, 0);
      check("post_reset_n_9", bus.n_samples, 9);

      // Back-to-back windows, each opened in the DONE cycle of the previous one.
      idle_check(1);
      run_window(5, -1, 1'b1, 1'b0, 0, 0, 0);
      run_window(6, -1, 1'b1, 1'b1, 0, 0, 0);
      run_window(3, -1, 1'b1, 1'b1, 0, 0, 0);
      idle_check(2);

      // Long window: the count holds at its maximum, and the sums wrap or clip.
      run_window(CNT_MAX + 5, -1, 1'b1, 1'b0, 0, 0, 0);
      idle_check(1);

      // ACC_W=16 overflow: two products of 16384.
      b16.start  = 1'b1;
      b16.enable = 1'b1;
      b16.sample = -8'sd128;
      b16.ref_i  = -8'sd128;
      b16.ref_q  = 8'sd1;
      tick();
      b16.start  = 1'b0;
      tick();
      b16.enable = 1'b0;
      tick();
      check("acc16_valid", b16.valid, 1);
      check("acc16_n_samples", b16.n_samples, 2);
      check("acc16_q_sum", b16.q_sum, -256);
      check("acc16_i_sum", b16.i_sum, SAT_EN ? 32767 : -32768);
      check("acc16_sat", b16.sat, SAT_EN ? 1 : 0);
      tick();
      check("acc16_valid_drop", b16.valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
